// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
//   Shared definitions for the APB UART scheduler:
//   - UART register word offsets (paddr is the byte address bits [11:2])
//   - STATE / INTCLEAR bit positions and the INTCLEAR write values
//   - scheduler FSM states and APB phase-engine states
package uart_sched_pkg;

    localparam logic [9:0] REG_DATA     = 10'h000;
    localparam logic [9:0] REG_STATE    = 10'h001;
    localparam logic [9:0] REG_CTRL     = 10'h002;
    localparam logic [9:0] REG_INTCLEAR = 10'h003;
    localparam logic [9:0] REG_BAUDDIV  = 10'h004;

    // STATE register: bit 0 = TX buffer full, bit 1 = RX buffer full
    localparam int STATE_TXFULL_BIT = 0;
    localparam int STATE_RXFULL_BIT = 1;

    // INTCLEAR register: bit 1 = RX int, bits 2/3 = TX/RX overrun
    localparam int INTCLEAR_RX_BIT    = 1;
    localparam int INTCLEAR_TXOVR_BIT = 2;
    localparam int INTCLEAR_RXOVR_BIT = 3;

    localparam logic [31:0] INTCLEAR_RX  = 32'h0000_0002;
    localparam logic [31:0] INTCLEAR_OVR = 32'h0000_000C;

    typedef enum logic [2:0] {
        S_INIT_BAUD,
        S_INIT_CTRL,
        S_IDLE,
        S_TX_STAT,
        S_TX_DATA,
        S_RX_DATA,
        S_RX_CLR,
        S_OVR_CLR
    } sched_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } apb_phase_t;

endpackage

// File: rtl/uart_sched_apb_phase.sv
// uart_sched_apb_phase
//   APB3 SETUP/ACCESS engine. A start request is accepted while idle or in
//   the completion cycle of the current transfer, so a sequence of transfers
//   runs back-to-back with no idle cycle in between. Address, direction and
//   write data are latched on acceptance and held until the next acceptance.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 request a transfer (addr/write/wdata valid with it)
//   addr, write, wdata    transfer description
//   done                  ACCESS cycle with pready (transfer completes)
//   rdata                 read data (valid with done)
//   slverr                pslverr qualified by done
//   psel, penable, paddr, pwrite, pwdata   APB master outputs
//   prdata, pready, pslverr                APB slave responses
module uart_sched_apb_phase
    import uart_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        slverr,
    output logic        psel,
    output logic        penable,
    output logic [9:0]  paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    apb_phase_t phase;
    apb_phase_t phase_nxt;
    logic       accept;

    always_comb begin
        done      = (phase == PH_ACCESS) && pready;
        accept    = start && ((phase == PH_IDLE) || done);
        phase_nxt = phase;
        case (phase)
            PH_IDLE:   if (start) phase_nxt = PH_SETUP;
            PH_SETUP:  phase_nxt = PH_ACCESS;
            PH_ACCESS: if (pready) phase_nxt = start ? PH_SETUP : PH_IDLE;
            default:   phase_nxt = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase  <= PH_IDLE;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
        end else begin
            phase <= phase_nxt;
            if (accept) begin
                paddr  <= addr;
                pwrite <= write;
                pwdata <= wdata;
            end
        end
    end

    assign psel    = (phase != PH_IDLE);
    assign penable = (phase == PH_ACCESS);
    assign rdata   = prdata;
    assign slverr  = done && pslverr;

endmodule

// File: rtl/uart_apb_scheduler.sv
// uart_apb_scheduler
//   APB3 master owning one APB UART. After reset it writes BAUDDIV and CTRL,
//   then serves a TX byte stream (STATE poll + DATA write) and RX interrupts
//   (DATA read + INTCLEAR write) with round-robin arbitration on ties.
//   tx_ready, rx_valid and init_done are registered: they pulse/rise the
//   cycle after the completing APB transfer.
// Optional feature (macro UART_SCHED_OVR_EN): overrun interrupts txovrint /
//   rxovrint get top priority in IDLE and are cleared by writing 0xC to
//   INTCLEAR; ovr_cnt counts clears, saturating at 255.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   paddr, psel, penable, pwrite, pwdata, prdata, pready, pslverr   APB3
//   rxint                        UART RX interrupt level
//   tx_data, tx_valid, tx_ready  TX byte stream (tx_ready = one-cycle pulse)
//   rx_data, rx_valid            RX byte stream (rx_valid = one-cycle pulse)
//   init_done                    high once the init writes have completed
//   err                          sticky, set by any pslverr completion
//   txovrint, rxovrint, ovr_cnt  only with UART_SCHED_OVR_EN
module uart_apb_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = 16,
    parameter logic [7:0]  CTRL_INIT = 8'h0B
) (
    input  logic        clk,
    input  logic        reset,
    output logic [9:0]  paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic        rxint,
`ifdef UART_SCHED_OVR_EN
    input  logic        txovrint,
    input  logic        rxovrint,
    output logic [7:0]  ovr_cnt,
`endif
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        init_done,
    output logic        err
);

    sched_state_t state;
    sched_state_t state_nxt;
    logic         last_grant_tx;
    logic         grant_tx;
    logic         grant_rx;
    logic         launch;
    logic         done;
    logic         slverr;
    logic [31:0]  rdata;
    logic [9:0]   xfer_addr;
    logic         xfer_write;
    logic [31:0]  xfer_wdata;
    logic         tx_req;
    logic         rx_req;
    logic         ovr_req;
    logic         unused_rdata_hi;

    // While tx_ready is high the source has not yet had a chance to drop
    // tx_valid for the byte just written, so it must not be granted again.
    assign tx_req = tx_valid && !tx_ready;
    assign rx_req = rxint;
    assign unused_rdata_hi = ^rdata[31:8];

`ifdef UART_SCHED_OVR_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign ovr_req = txovrint || rxovrint;
`else
    assign ovr_req = 1'b0;
`endif

    // Next state plus launch of the transfer belonging to state_nxt. A
    // transfer is launched on entry from IDLE, back-to-back on completion
    // inside a sequence, and once after reset for the first init write.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        grant_tx  = 1'b0;
        grant_rx  = 1'b0;
        case (state)
            S_INIT_BAUD: begin
                if (done) begin
                    state_nxt = S_INIT_CTRL;
                    launch    = 1'b1;
                end else if (!psel) begin
                    launch = 1'b1;
                end
            end
            S_INIT_CTRL: if (done) state_nxt = S_IDLE;
            S_IDLE: begin
                if (ovr_req) begin
                    state_nxt = S_OVR_CLR;
                end else if (tx_req && (!rx_req || !last_grant_tx)) begin
                    state_nxt = S_TX_STAT;
                    grant_tx  = 1'b1;
                end else if (rx_req) begin
                    state_nxt = S_RX_DATA;
                    grant_rx  = 1'b1;
                end
                launch = (state_nxt != S_IDLE);
            end
            S_TX_STAT: begin
                if (done) begin
                    if (rdata[STATE_TXFULL_BIT]) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_TX_DATA;
                        launch    = 1'b1;
                    end
                end
            end
            S_TX_DATA: if (done) state_nxt = S_IDLE;
            S_RX_DATA: begin
                if (done) begin
                    state_nxt = S_RX_CLR;
                    launch    = 1'b1;
                end
            end
            S_RX_CLR:  if (done) state_nxt = S_IDLE;
            S_OVR_CLR: if (done) state_nxt = S_IDLE;
            default:   state_nxt = S_INIT_BAUD;
        endcase

        xfer_addr  = REG_DATA;
        xfer_write = 1'b0;
        xfer_wdata = '0;
        case (state_nxt)
            S_INIT_BAUD: begin
                xfer_addr  = REG_BAUDDIV;
                xfer_write = 1'b1;
                xfer_wdata = 32'(BAUD_DIV);
            end
            S_INIT_CTRL: begin
                xfer_addr  = REG_CTRL;
                xfer_write = 1'b1;
                xfer_wdata = {24'h0, CTRL_INIT};
            end
            S_TX_STAT: xfer_addr = REG_STATE;
            S_TX_DATA: begin
                xfer_addr  = REG_DATA;
                xfer_write = 1'b1;
                xfer_wdata = {24'h0, tx_data};
            end
            S_RX_DATA: xfer_addr = REG_DATA;
            S_RX_CLR: begin
                xfer_addr  = REG_INTCLEAR;
                xfer_write = 1'b1;
                xfer_wdata = INTCLEAR_RX;
            end
            S_OVR_CLR: begin
                xfer_addr  = REG_INTCLEAR;
                xfer_write = 1'b1;
                xfer_wdata = INTCLEAR_OVR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_INIT_BAUD;
            last_grant_tx <= 1'b0;
            init_done     <= 1'b0;
            tx_ready      <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            err           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_tx) begin
                last_grant_tx <= 1'b1;
            end else if (grant_rx) begin
                last_grant_tx <= 1'b0;
            end
            if ((state == S_INIT_CTRL) && done) init_done <= 1'b1;
            tx_ready <= (state == S_TX_DATA) && done;
            rx_valid <= (state == S_RX_DATA) && done;
            if ((state == S_RX_DATA) && done) rx_data <= rdata[7:0];
            if (slverr) err <= 1'b1;
        end
    end

`ifdef UART_SCHED_OVR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt <= '0;
        end else if ((state == S_OVR_CLR) && done) begin
            ovr_cnt <= sat_inc8(ovr_cnt);
        end
    end
`endif

    uart_sched_apb_phase u_phase (
        .clk     (clk),
        .reset   (reset),
        .start   (launch),
        .addr    (xfer_addr),
        .write   (xfer_write),
        .wdata   (xfer_wdata),
        .done    (done),
        .rdata   (rdata),
        .slverr  (slverr),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

endmodule

// File: tb/tb_uart_apb_scheduler.sv
// tb_uart_apb_scheduler
//   Directed bench for uart_apb_scheduler (default build, no overrun ports).
//   A small APB UART slave model answers STATE/DATA reads and can insert
//   wait states or pslverr on a chosen address.
module tb_uart_apb_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic        rxint = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        init_done;
    logic        err;

    int errors = 0;
    int checks = 0;

    // slave configuration, written only by the test tasks
    int         stat_full_n = 0;
    int         stat_base = 0;
    logic [7:0] rx_byte = '0;
    logic [9:0] wait_addr = 10'h3FF;
    int         wait_cfg = 0;
    logic       err_en = 1'b0;
    logic [9:0] err_addr = '0;

    // slave/monitor state, written only by the model processes
    int          acc_cnt = 0;
    int          stat_reads = 0;
    int          data_wr = 0;
    int          data_rd = 0;
    int          clr_wr = 0;
    logic [31:0] last_data_wdata = '0;
    logic [31:0] last_clr_wdata = '0;
    byte         seq_q[$];

    always #5 clk = ~clk;

    uart_apb_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .rxint     (rxint),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .init_done (init_done),
        .err       (err)
    );

    // slave responses, updated away from the active edge
    always @(negedge clk) begin
        if (psel && penable) begin
            pready  = (acc_cnt >= ((paddr == wait_addr) ? wait_cfg : 0));
            pslverr = err_en && (paddr == err_addr);
            if (paddr == 10'h001)
                prdata = ((stat_reads - stat_base) < stat_full_n) ? 32'h1 : 32'h0;
            else if (paddr == 10'h000)
                prdata = {24'h0, rx_byte};
            else
                prdata = 32'h0;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = 32'h0;
        end
    end

    // transfer log
    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (psel && penable && pready) begin
            if (paddr == 10'h001) stat_reads <= stat_reads + 1;
            if (paddr == 10'h000 && pwrite) begin
                data_wr <= data_wr + 1;
                last_data_wdata <= pwdata;
                seq_q.push_back("T");
            end
            if (paddr == 10'h000 && !pwrite) begin
                data_rd <= data_rd + 1;
                seq_q.push_back("R");
            end
            if (paddr == 10'h003) begin
                clr_wr <= clr_wr + 1;
                last_clr_wdata <= pwdata;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({psel, penable, pwrite, tx_ready, rx_valid, init_done, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {psel, penable, pwrite, tx_ready, rx_valid, init_done, err});
        end
        checks++;
        if (paddr !== 10'h0) begin
            errors++;
            $display("FAIL reset_paddr: got %0h expected 0", paddr);
        end
        checks++;
        if (pwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_pwdata: got %0h expected 0", pwdata);
        end
        checks++;
        if (rx_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_rx_data: got %0h expected 0", rx_data);
        end
    endtask

    task automatic test_init();
        logic       e_psel, e_pen, e_init;
        logic [9:0] e_addr;
        logic [31:0] e_wdata;
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            e_psel  = (k >= 1 && k <= 4);
            e_pen   = (k == 2 || k == 4);
            e_addr  = (k <= 2) ? 10'h004 : 10'h002;
            e_wdata = (k <= 2) ? 32'h10 : 32'h0B;
            e_init  = (k >= 5);
            checks++;
            if ({psel, penable, init_done} !== {e_psel, e_pen, e_init}) begin
                errors++;
                $display("FAIL init_ctrl_c%0d: got %b expected %b", k,
                         {psel, penable, init_done}, {e_psel, e_pen, e_init});
            end
            if (e_psel) begin
                checks++;
                if ({paddr, pwrite, pwdata} !== {e_addr, 1'b1, e_wdata}) begin
                    errors++;
                    $display("FAIL init_xfer_c%0d: got addr=%0h wr=%b data=%0h expected addr=%0h wr=1 data=%0h",
                             k, paddr, pwrite, pwdata, e_addr, e_wdata);
                end
            end
        end
    endtask

    task automatic test_tx_basic();
        int dw0;
        dw0 = data_wr;
        stat_full_n = 0;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (tx_ready !== (k == 5)) begin
                errors++;
                $display("FAIL tx_ready_c%0d: got %b expected %b", k, tx_ready, (k == 5));
            end
            if (k == 1) begin
                checks++;
                if ({psel, penable, paddr, pwrite} !== {2'b10, 10'h001, 1'b0}) begin
                    errors++;
                    $display("FAIL tx_stat_setup: got sel=%b en=%b addr=%0h wr=%b expected 1 0 1 0",
                             psel, penable, paddr, pwrite);
                end
            end
            if (k == 3) begin
                checks++;
                if ({psel, penable, paddr, pwrite, pwdata} !== {2'b10, 10'h000, 1'b1, 32'hA5}) begin
                    errors++;
                    $display("FAIL tx_data_setup: got sel=%b en=%b addr=%0h wr=%b data=%0h expected 1 0 0 1 a5",
                             psel, penable, paddr, pwrite, pwdata);
                end
            end
            if (k == 5) tx_valid = 1'b0;
        end
        checks++;
        if ((data_wr - dw0) !== 1 || last_data_wdata !== 32'hA5) begin
            errors++;
            $display("FAIL tx_data_write: got %0d writes last=%0h expected 1 write of a5",
                     data_wr - dw0, last_data_wdata);
        end
    endtask

    task automatic test_tx_retry();
        int s0, dw0, pulses;
        s0 = stat_reads;
        dw0 = data_wr;
        pulses = 0;
        stat_base = stat_reads;
        stat_full_n = 2;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (tx_ready) begin
                pulses++;
                tx_valid = 1'b0;
            end
        end
        stat_full_n = 0;
        checks++;
        if ((stat_reads - s0) !== 3) begin
            errors++;
            $display("FAIL retry_stat_reads: got %0d expected 3", stat_reads - s0);
        end
        checks++;
        if ((data_wr - dw0) !== 1 || last_data_wdata !== 32'h5A) begin
            errors++;
            $display("FAIL retry_data_write: got %0d writes last=%0h expected 1 write of 5a",
                     data_wr - dw0, last_data_wdata);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL retry_tx_ready: got %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_rx();
        int c0;
        c0 = clr_wr;
        rx_byte = 8'h3C;
        rxint = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (rx_valid !== (k == 3)) begin
                errors++;
                $display("FAIL rx_valid_c%0d: got %b expected %b", k, rx_valid, (k == 3));
            end
            if (k == 1) begin
                checks++;
                if ({psel, penable, paddr, pwrite} !== {2'b10, 10'h000, 1'b0}) begin
                    errors++;
                    $display("FAIL rx_read_setup: got sel=%b en=%b addr=%0h wr=%b expected 1 0 0 0",
                             psel, penable, paddr, pwrite);
                end
            end
            if (k == 3) begin
                checks++;
                if (rx_data !== 8'h3C) begin
                    errors++;
                    $display("FAIL rx_data: got %0h expected 3c", rx_data);
                end
                checks++;
                if ({psel, penable, paddr, pwrite, pwdata} !== {2'b10, 10'h003, 1'b1, 32'h2}) begin
                    errors++;
                    $display("FAIL rx_clr_setup: got sel=%b en=%b addr=%0h wr=%b data=%0h expected 1 0 3 1 2",
                             psel, penable, paddr, pwrite, pwdata);
                end
            end
            if (k == 4) rxint = 1'b0;
        end
        repeat (3) step();
        checks++;
        if ((clr_wr - c0) !== 1 || last_clr_wdata !== 32'h2) begin
            errors++;
            $display("FAIL rx_intclear: got %0d writes last=%0h expected 1 write of 2",
                     clr_wr - c0, last_clr_wdata);
        end
        checks++;
        if (rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL rx_data_hold: got %0h expected 3c", rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int s0, stall, addr_bad;
        logic [42:0] cap;
        s0 = seq_q.size();
        stall = 0;
        addr_bad = 0;
        cap = '0;
        wait_addr = 10'h003;
        wait_cfg = 2;
        tx_data = 8'h11;
        rx_byte = 8'h77;
        tx_valid = 1'b1;
        rxint = 1'b1;
        for (int c = 0; c < 150 && seq_q.size() < s0 + 3; c++) begin
            step();
            if (psel && !penable) begin
                cap = {paddr, pwrite, pwdata};
            end else if (psel && penable) begin
                if ({paddr, pwrite, pwdata} != cap) addr_bad++;
                if (!pready) stall++;
            end
        end
        tx_valid = 1'b0;
        rxint = 1'b0;
        checks++;
        if (seq_q.size() - s0 !== 3) begin
            errors++;
            $display("FAIL arb_count: got %0d sequences expected 3", seq_q.size() - s0);
        end else begin
            checks++;
            if (seq_q[s0] !== "T" || seq_q[s0+1] !== "R" || seq_q[s0+2] !== "T") begin
                errors++;
                $display("FAIL arb_order: got %c%c%c expected TRT",
                         seq_q[s0], seq_q[s0+1], seq_q[s0+2]);
            end
        end
        checks++;
        if (stall !== 2) begin
            errors++;
            $display("FAIL wait_stretch: got %0d stalled access cycles expected 2", stall);
        end
        checks++;
        if (addr_bad !== 0) begin
            errors++;
            $display("FAIL addr_stable: got %0d unstable access cycles expected 0", addr_bad);
        end
        wait_cfg = 0;
        repeat (20) step();
    endtask

    task automatic test_err_and_reset();
        logic found;
        reset = 1'b1;
        err_en = 1'b1;
        err_addr = 10'h002;
        repeat (2) step();
        reset = 1'b0;
        repeat (8) step();
        checks++;
        if ({err, init_done} !== 2'b11) begin
            errors++;
            $display("FAIL err_set: got err=%b init_done=%b expected 1 1", err, init_done);
        end
        err_en = 1'b0;
        repeat (5) step();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
        wait_addr = 10'h001;
        wait_cfg = 5;
        tx_data = 8'h22;
        tx_valid = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (psel && penable) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_access_reach: got no access phase expected one");
        end
        reset = 1'b1;
        step();
        checks++;
        if ({psel, penable, err, init_done} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset: got sel=%b en=%b err=%b init=%b expected 0 0 0 0",
                     psel, penable, err, init_done);
        end
        tx_valid = 1'b0;
        wait_cfg = 0;
        reset = 1'b0;
        step();
        checks++;
        if ({psel, penable, paddr, pwrite, pwdata} !== {2'b10, 10'h004, 1'b1, 32'h10}) begin
            errors++;
            $display("FAIL init_restart: got sel=%b en=%b addr=%0h wr=%b data=%0h expected 1 0 4 1 10",
                     psel, penable, paddr, pwrite, pwdata);
        end
        repeat (4) step();
        checks++;
        if ({init_done, err} !== 2'b10) begin
            errors++;
            $display("FAIL reinit_done: got init=%b err=%b expected 1 0", init_done, err);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_tx_basic();
        test_tx_retry();
        test_rx();
        test_back_to_back();
        test_err_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
